// File: rtl/enc_stage_1.sv
// ============================================================================
//  Module   : enc_stage_1
//  Purpose  : First stage of the extended-Hamming encoder pipeline. Takes a
//             right-aligned info word plus a work mode, computes the Hamming
//             parity bits for that mode and buffers the packed codeword
//             (overall-parity slot left at 0) in a 2-entry output FIFO.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk        in   clock
//    rst        in   asynchronous, active-low reset
//    in_valid   in   info_in/work_mod valid
//    in_ready   out  a word can be accepted this cycle (registered state only)
//    info_in    in   info bits, right-aligned
//    work_mod   in   0 = (8,4), 1 = (16,11), 2 = (32,26)
//    out_valid  out  data_out/mod_out valid
//    out_ready  in   downstream accepts the head word
//    data_out   out  packed codeword, overall-parity slot = 0
//    mod_out    out  mode travelling with data_out
//    mode_err   out  one-cycle pulse after an illegal-mode word is offered
// ============================================================================
`default_nettype none

module enc_stage_1 #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int AMBA_WORD          = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_INFO_WIDTH-1:0]     info_in,
    input  logic [AMBA_WORD-1:0]          work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [AMBA_WORD-1:0]          mod_out,
    output logic                          mode_err
);

    // Parity coverage masks over the packed codeword.
    localparam logic [31:0] C_M1_P2 = 32'h0000_00E0;
    localparam logic [31:0] C_M1_P1 = 32'h0000_00D0;
    localparam logic [31:0] C_M1_P0 = 32'h0000_00B0;
    localparam logic [31:0] C_M2_P3 = 32'h0000_FE00;
    localparam logic [31:0] C_M2_P2 = 32'h0000_F1C0;
    localparam logic [31:0] C_M2_P1 = 32'h0000_CDA0;
    localparam logic [31:0] C_M2_P0 = 32'h0000_AB60;
    localparam logic [31:0] C_M3_P4 = 32'hFFFE_0000;
    localparam logic [31:0] C_M3_P3 = 32'hFF01_FC00;
    localparam logic [31:0] C_M3_P2 = 32'hF0F1_E380;
    localparam logic [31:0] C_M3_P1 = 32'hCCCD_9B40;
    localparam logic [31:0] C_M3_P0 = 32'hAAAB_56C0;

    localparam logic [1:0] C_FULL = 2'd2;

    logic [25:0] info_ext;
    logic [31:0] cw_info;   // info bits placed, parity slots still 0
    logic [31:0] cw_full;
    logic        legal;

    logic                          accept;
    logic                          push;
    logic                          pop;

    logic [1:0]                    count_q,    count_d;
    logic [MAX_CODEWORD_WIDTH-1:0] head_cw_q,  head_cw_d;
    logic [MAX_CODEWORD_WIDTH-1:0] tail_cw_q,  tail_cw_d;
    logic [AMBA_WORD-1:0]          head_mod_q, head_mod_d;
    logic [AMBA_WORD-1:0]          tail_mod_q, tail_mod_d;
    logic                          err_q,      err_d;

    // ------------------------------------------------------------------
    // Encoder: place info bits, then derive parity from the placed bits.
    // Modes wider than the configured codeword are illegal.
    // ------------------------------------------------------------------
    always_comb begin
        info_ext                       = '0;
        info_ext[MAX_INFO_WIDTH-1:0]   = info_in;
        cw_info                        = '0;
        cw_full                        = '0;
        legal                          = 1'b0;
        if (work_mod == AMBA_WORD'(0)) begin
            legal          = 1'b1;
            cw_info[7:4]   = info_ext[3:0];
            cw_full        = cw_info;
            cw_full[2]     = ^(cw_info & C_M1_P2);
            cw_full[1]     = ^(cw_info & C_M1_P1);
            cw_full[0]     = ^(cw_info & C_M1_P0);
        end else if (work_mod == AMBA_WORD'(1)) begin
            legal          = (MAX_CODEWORD_WIDTH >= 16);
            cw_info[15:5]  = info_ext[10:0];
            cw_full        = cw_info;
            cw_full[3]     = ^(cw_info & C_M2_P3);
            cw_full[2]     = ^(cw_info & C_M2_P2);
            cw_full[1]     = ^(cw_info & C_M2_P1);
            cw_full[0]     = ^(cw_info & C_M2_P0);
        end else if (work_mod == AMBA_WORD'(2)) begin
            legal          = (MAX_CODEWORD_WIDTH >= 32);
            cw_info[31:6]  = info_ext[25:0];
            cw_full        = cw_info;
            cw_full[4]     = ^(cw_info & C_M3_P4);
            cw_full[3]     = ^(cw_info & C_M3_P3);
            cw_full[2]     = ^(cw_info & C_M3_P2);
            cw_full[1]     = ^(cw_info & C_M3_P1);
            cw_full[0]     = ^(cw_info & C_M3_P0);
        end
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO: head slot always drives the outputs; the tail slot is
    // cleared when it shifts into the head so an empty FIFO reads as 0.
    // ------------------------------------------------------------------
    assign in_ready = (count_q != C_FULL);
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign pop      = (count_q != 2'd0) && out_ready;

    always_comb begin
        count_d    = count_q;
        head_cw_d  = head_cw_q;
        tail_cw_d  = tail_cw_q;
        head_mod_d = head_mod_q;
        tail_mod_d = tail_mod_q;
        err_d      = accept && !legal;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_cw_d  = cw_full[MAX_CODEWORD_WIDTH-1:0];
                    head_mod_d = work_mod;
                end else begin
                    tail_cw_d  = cw_full[MAX_CODEWORD_WIDTH-1:0];
                    tail_mod_d = work_mod;
                end
            end
            2'b01: begin
                count_d    = count_q - 2'd1;
                head_cw_d  = tail_cw_q;
                head_mod_d = tail_mod_q;
                tail_cw_d  = '0;
                tail_mod_d = '0;
            end
            2'b11: begin
                // Only reachable with one entry held: the new word replaces it.
                head_cw_d  = cw_full[MAX_CODEWORD_WIDTH-1:0];
                head_mod_d = work_mod;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            head_cw_q  <= '0;
            tail_cw_q  <= '0;
            head_mod_q <= '0;
            tail_mod_q <= '0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            head_cw_q  <= head_cw_d;
            tail_cw_q  <= tail_cw_d;
            head_mod_q <= head_mod_d;
            tail_mod_q <= tail_mod_d;
            err_q      <= err_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign data_out  = head_cw_q;
    assign mod_out   = head_mod_q;
    assign mode_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_enc_stage_1.sv
// ============================================================================
//  Module   : tb_enc_stage_1
//  Purpose  : Self-checking bench for enc_stage_1 (32-bit default instance
//             plus a 16-bit instance for width-dependent mode legality).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enc_stage_1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] info_in = '0;
    logic [31:0] work_mod = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;
    logic [31:0] mod_out;
    logic        mode_err;

    logic        v_in_valid = 1'b0;
    logic        v_in_ready;
    logic [10:0] v_info = '0;
    logic [31:0] v_mod = '0;
    logic        v_out_valid;
    logic        v_out_ready = 1'b1;
    logic [15:0] v_data;
    logic [31:0] v_mod_out;
    logic        v_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    enc_stage_1 #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .AMBA_WORD(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .info_in(info_in), .work_mod(work_mod), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .mod_out(mod_out),
        .mode_err(mode_err)
    );

    enc_stage_1 #(.MAX_CODEWORD_WIDTH(16), .MAX_INFO_WIDTH(11), .AMBA_WORD(32)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .info_in(v_info), .work_mod(v_mod), .out_valid(v_out_valid),
        .out_ready(v_out_ready), .data_out(v_data), .mod_out(v_mod_out),
        .mode_err(v_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rng(input int hi, input int lo);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Bits covered by parity bit j of the given mode, straight from the equations.
    function automatic logic [31:0] pmask(input int mode, input int j);
        logic [31:0] m = '0;
        if (mode == 0) begin
            case (j)
                2: m = rng(7, 5);
                1: m = rng(7, 6) | rng(4, 4);
                0: m = rng(7, 7) | rng(5, 4);
                default: m = '0;
            endcase
        end else if (mode == 1) begin
            case (j)
                3: m = rng(15, 9);
                2: m = rng(15, 12) | rng(8, 6);
                1: m = rng(15, 14) | rng(11, 10) | rng(8, 7) | rng(5, 5);
                0: m = rng(15, 15) | rng(13, 13) | rng(11, 11) | rng(9, 8) | rng(6, 5);
                default: m = '0;
            endcase
        end else begin
            case (j)
                4: m = rng(31, 17);
                3: m = rng(31, 24) | rng(16, 10);
                2: m = rng(31, 28) | rng(23, 20) | rng(16, 13) | rng(9, 7);
                1: m = rng(31, 30) | rng(27, 26) | rng(23, 22) | rng(19, 18) |
                       rng(16, 15) | rng(12, 11) | rng(9, 8) | rng(6, 6);
                0: begin
                    for (int b = 17; b <= 31; b += 2) m[b] = 1'b1;
                    m = m | rng(16, 16) | rng(14, 14) | rng(12, 12) | rng(10, 9) | rng(7, 6);
                end
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    function automatic logic [31:0] enc(input logic [25:0] info, input int mode);
        int k = (mode == 0) ? 4 : (mode == 1) ? 11 : 26;
        int r = mode + 3;
        logic [31:0] cw = '0;
        for (int i = 0; i < k; i++) cw[i + r + 1] = info[i];
        for (int j = 0; j < r; j++) cw[j] = ^(cw & pmask(mode, j));
        return cw;
    endfunction

    logic [63:0] mq[$];
    logic        err_exp = 1'b0;
    int          msz;
    logic        macc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            err_exp = 1'b0;
        end else begin
            msz  = mq.size();
            macc = in_valid && (msz != 2);
            err_exp = macc && (work_mod > 32'd2);
            if (out_ready && msz != 0) void'(mq.pop_front());
            if (macc && work_mod <= 32'd2)
                mq.push_back({enc(info_in, int'(work_mod)), work_mod});
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(mq.size() != 2));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("data_out", data_out, mq[0][63:32]);
            chk("mod_out", mod_out, mq[0][31:0]);
        end
        chk("mode_err", 32'(mode_err), 32'(err_exp));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        #8;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_mod_out", mod_out, 32'd0);
        chk("rst_mode_err", 32'(mode_err), 32'd0);
        #4 rst = 1'b1;

        chk("model_m1", enc(26'hB, 0), 32'h0000_00B1);
        chk("model_m2", enc(26'h7FF, 1), 32'h0000_FFEF);
        chk("model_m3", enc(26'h1, 2), 32'h0000_0043);

        cyc();
        // mode1 literal with one-edge latency
        in_valid = 1'b1; work_mod = 32'd0; info_in = 26'h3FFFFFB; out_ready = 1'b1;
        cyc();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("m1_data", data_out, 32'h0000_00B1);
        chk("m1_mod", mod_out, 32'd0);
        work_mod = 32'd1; info_in = 26'h7FF;
        cyc();
        chk("m2_data", data_out, 32'h0000_FFEF);
        work_mod = 32'd2; info_in = 26'h1;
        cyc();
        chk("m3_data", data_out, 32'h0000_0043);
        chk("m3_mod", mod_out, 32'd2);
        for (int i = 0; i < 26; i++) begin
            info_in = 26'h1 << i;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();

        // stall: three words offered, two accepted
        out_ready = 1'b0; in_valid = 1'b1; work_mod = 32'd0; info_in = 26'hB;
        cyc();
        work_mod = 32'd1; info_in = 26'h123;
        cyc();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        work_mod = 32'd2; info_in = 26'h2AAAAAA;
        cyc();
        chk("stall_hold", data_out, 32'h0000_00B1);
        cyc();
        chk("stall_hold2", data_out, 32'h0000_00B1);
        out_ready = 1'b1;
        cyc();
        chk("pop_in_ready", 32'(in_ready), 32'd1);
        chk("pop_second", data_out, enc(26'h123, 1));
        cyc();
        chk("pushpop_head", data_out, enc(26'h2AAAAAA, 2));
        chk("pushpop_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        cyc();

        // illegal modes, including mode2 on the 16-bit instance
        in_valid = 1'b1; work_mod = 32'd3;
        v_in_valid = 1'b1; v_mod = 32'd2; v_info = 11'h7FF;
        cyc();
        chk("err_pulse", 32'(mode_err), 32'd1);
        chk("err_no_buf", 32'(out_valid), 32'd0);
        chk("w16_err", 32'(v_err), 32'd1);
        chk("w16_no_buf", 32'(v_out_valid), 32'd0);
        work_mod = 32'h8000_0000;
        v_mod = 32'd1;
        cyc();
        chk("w16_m2_data", 32'(v_data), 32'h0000_FFEF);
        chk("w16_err_clr", 32'(v_err), 32'd0);
        in_valid = 1'b0; v_in_valid = 1'b0;
        cyc();
        chk("err_clr", 32'(mode_err), 32'd0);

        // randomized traffic with an asynchronous reset in the middle
        for (int c = 0; c < 400; c++) begin
            int r;
            in_valid  = ($urandom % 4) != 0;
            info_in   = 26'($urandom);
            r         = int'($urandom % 16);
            work_mod  = (r < 5) ? 32'd0 : (r < 10) ? 32'd1 : (r < 15) ? 32'd2 :
                        (($urandom % 2) != 0) ? 32'd3 : $urandom;
            out_ready = ($urandom % 3) != 0;
            if (c == 200) begin
                #1 rst = 1'b0;
                #1;
                chk("async_out_valid", 32'(out_valid), 32'd0);
                chk("async_data_out", data_out, 32'd0);
                chk("async_in_ready", 32'(in_ready), 32'd1);
                cyc();
                rst = 1'b1;
            end
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/enc_stage_1.md
# enc_stage_1

First stage of the extended-Hamming encoder pipeline. It accepts a right-aligned info word and a work mode over a valid/ready handshake and computes the Hamming parity bits for that mode. It emits the codeword in packed layout with the overall-parity slot cleared to 0; enc_stage_2 fills that slot downstream. A two-entry output buffer decouples input acceptance from downstream stalls.

## Interface

Parameters:
- MAX_CODEWORD_WIDTH, 32: codeword width; legal values 8, 16, 32.
- MAX_INFO_WIDTH, 26: info width; must be 4, 11 or 26 to match MAX_CODEWORD_WIDTH.
- AMBA_WORD, 32: width of the work_mod bus.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  info_in/work_mod valid.
- in_ready  out  1  block can accept a word this cycle.
- info_in  in  MAX_INFO_WIDTH  info bits, right-aligned.
- work_mod  in  AMBA_WORD  0 = mode1 (8,4), 1 = mode2 (16,11), 2 = mode3 (32,26).
- out_valid  out  1  data_out/mod_out valid.
- out_ready  in  1  downstream accepts the word.
- data_out  out  MAX_CODEWORD_WIDTH  packed codeword; overall-parity slot = 0.
- mod_out  out  AMBA_WORD  work_mod travelling with data_out.
- mode_err  out  1  one-cycle pulse when an offered word carries an illegal mode.

## Operation

- A word transfers in when in_valid & in_ready. A word transfers out when out_valid & out_ready.
- Legal modes by width:
  - Width 8: mode1 only.
  - Width 16: mode1 and mode2.
  - Width 32: all three modes.
- Illegal mode (any other work_mod value) on a transfer-in:
  - The word is dropped and not buffered.
  - mode_err = 1 in the next cycle.
  - in_ready still gates acceptance.
- Info bits above the mode's info width are ignored. Codeword bits above the mode's codeword width are 0.
- Layout, with cw = data_out:
  - mode1: cw[7:4] = info[3:0], cw[3] = 0, cw[2:0] = p.
  - mode2: cw[15:5] = info[10:0], cw[4] = 0, cw[3:0] = p.
  - mode3: cw[31:6] = info[25:0], cw[5] = 0, cw[4:0] = p.
- Parity equations; each parity bit is the XOR of the listed cw bits.
- mode1:
  - p2 = 7,6,5.
  - p1 = 7,6,4.
  - p0 = 7,5,4.
- mode2:
  - p3 = 15..9.
  - p2 = 15..12, 8, 7, 6.
  - p1 = 15, 14, 11, 10, 8, 7, 5.
  - p0 = 15, 13, 11, 9, 8, 6, 5.
- mode3:
  - p4 = 31..17.
  - p3 = 31..24, 16..10.
  - p2 = 31..28, 23..20, 16..13, 9, 8, 7.
  - p1 = 31, 30, 27, 26, 23, 22, 19, 18, 16, 15, 12, 11, 9, 8, 6.
  - p0 = 31, 29, 27, 25, 23, 21, 19, 17, 16, 14, 12, 10, 9, 7, 6.
- Parity is computed at the input and stored already encoded. The buffer holds {codeword, mode}.
- Buffer is a 2-entry FIFO with count ∈ {0, 1, 2}.
  - in_ready = (count != 2). It depends only on registered state, never combinationally on out_ready.
  - out_valid = (count != 0). The head entry drives data_out and mod_out.
- Count update:
  - Push only: count + 1.
  - Pop only: count − 1.
  - Push and pop together at count 1: count stays 1, and the new word becomes head next cycle.
  - count 2: no push is possible; a pop frees one slot.
- Output stability: while out_valid & !out_ready, data_out and mod_out hold constant.

## Timing

- Reset values: in_ready = 1, out_valid = 0, data_out = 0, mod_out = 0, mode_err = 0, count = 0. Stored entries clear to 0.
- Latency: a word accepted at edge N with count 0 is on data_out with out_valid = 1 after edge N.
- Throughput: one word per cycle with out_ready held high.
- A full buffer deasserts in_ready on the cycle after the second unpopped push.
- Reset mid-operation: buffered words are discarded immediately (asynchronous). Outputs go to their reset values without waiting for clk.

## Test plan

- Reset, then mode1, info 4'b1011 -> data_out = 0x000000B1, mod_out = 0, out_valid one cycle after the accept.
- mode2, info 11'h7FF -> data_out = 0x0000FFEF.
- mode3, info 26'h0000001 -> data_out = 0x00000043. Then sweep all 26 single-bit infos and check against the equations.
- Hold out_ready = 0 and offer 3 words:
  - The first two are accepted, then in_ready = 0.
  - Raise out_ready: words emerge in order and data_out holds stable while stalled.
  - in_ready returns to 1 the cycle after the first pop.
- work_mod = 3 with in_valid -> mode_err pulses once, nothing is buffered, and out_valid stays 0. Repeat with work_mod = 2 at MAX_CODEWORD_WIDTH = 16.
- With count 1, push and pop in the same cycle -> count stays 1 and the new word is on data_out next cycle. Assert rst mid-stream -> out_valid = 0 and data_out = 0 asynchronously.
